press_classifier_ip: RTL and testbench



---
 rtl/press_classifier_ip.sv | 133 +++++++++++++
 tb/tb_press_classifier_ip.sv | 135 +++++++++++++
 2 files changed

// File: rtl/press_classifier_ip.sv
// Button gesture classifier: turns a debounced level into one-cycle pulses for
// single click, double click and long press, plus hold/busy status levels.
module press_classifier_ip #(
   parameter int unsigned LongCycles = 50_000_000,
   parameter int unsigned GapCycles  = 25_000_000
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic level_i,
   output logic short_o,
   output logic double_o,
   output logic long_o,
   output logic hold_o,
   output logic busy_o
);

   localparam int unsigned MaxCycles = (LongCycles > GapCycles) ? LongCycles : GapCycles;
   localparam int unsigned CntW      = $clog2(MaxCycles + 1);

   localparam logic [CntW-1:0] CntOne   = CntW'(1);
   localparam logic [CntW-1:0] LongLast = CntW'(LongCycles - 1);
   localparam logic [CntW-1:0] GapLast  = CntW'(GapCycles - 1);

   generate
      if (LongCycles < 2) begin : g_bad_long
         $error("press_classifier_ip: LongCycles must be >= 2");
      end
      if (GapCycles < 2) begin : g_bad_gap
         $error("press_classifier_ip: GapCycles must be >= 2");
      end
   endgenerate

   typedef enum logic [2:0] {
      StArm,
      StIdle,
      StPress1,
      StGap,
      StPress2,
      StLong
   } state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            short_q, short_d;
   logic            double_q, double_d;
   logic            long_q, long_d;
   logic            hold_q, hold_d;
   logic            busy_q, busy_d;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      short_d  = 1'b0;
      double_d = 1'b0;
      long_d   = 1'b0;

      case (state_q)
         // Wait for a release so a button held through reset is not a press.
         StArm: begin
            if (!level_i) state_d = StIdle;
         end
         StIdle: begin
            if (level_i) begin
               state_d = StPress1;
               cnt_d   = CntOne;
            end
         end
         StPress1: begin
            if (level_i) begin
               if (cnt_q == LongLast) begin
                  long_d  = 1'b1;
                  state_d = StLong;
               end else begin
                  cnt_d = cnt_q + CntOne;
               end
            end else begin
               state_d = StGap;
               cnt_d   = CntOne;
            end
         end
         StGap: begin
            if (!level_i) begin
               if (cnt_q == GapLast) begin
                  short_d = 1'b1;
                  state_d = StIdle;
               end else begin
                  cnt_d = cnt_q + CntOne;
               end
            end else begin
               double_d = 1'b1;
               state_d  = StPress2;
            end
         end
         // Second press of a double click has no long-press detection.
         StPress2, StLong: begin
            if (!level_i) state_d = StIdle;
         end
         default: begin
            state_d = StArm;
         end
      endcase

      hold_d = (state_d == StLong);
      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= StArm;
         cnt_q    <= '0;
         short_q  <= 1'b0;
         double_q <= 1'b0;
         long_q   <= 1'b0;
         hold_q   <= 1'b0;
         busy_q   <= 1'b1;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         short_q  <= short_d;
         double_q <= double_d;
         long_q   <= long_d;
         hold_q   <= hold_d;
         busy_q   <= busy_d;
      end
   end

   assign short_o  = short_q;
   assign double_o = double_q;
   assign long_o   = long_q;
   assign hold_o   = hold_q;
   assign busy_o   = busy_q;

endmodule

// File: tb/tb_press_classifier_ip.sv
// Directed bench for press_classifier_ip with LongCycles=8, GapCycles=5.
// Expected outputs are packed as {short, double, long, hold, busy}.
module tb_press_classifier_ip;

   logic clk_i = 1'b0;
   logic rst_i;
   logic level_i;
   logic short_o, double_o, long_o, hold_o, busy_o;

   int n_assert = 0;
   int n_fail   = 0;
   int step_no  = 0;

   localparam logic [4:0] IDL = 5'b00000;
   localparam logic [4:0] BSY = 5'b00001;
   localparam logic [4:0] SHT = 5'b10000;
   localparam logic [4:0] DBL = 5'b01001;
   localparam logic [4:0] LNG = 5'b00111;
   localparam logic [4:0] HLD = 5'b00011;

   press_classifier_ip #(
      .LongCycles(8),
      .GapCycles (5)
   ) dut (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .level_i (level_i),
      .short_o (short_o),
      .double_o(double_o),
      .long_o  (long_o),
      .hold_o  (hold_o),
      .busy_o  (busy_o)
   );

   always #5 clk_i = ~clk_i;

   // Apply one sample, let the edge take it, then check the registered result.
   task automatic step(input logic lvl, input logic [4:0] exp, input string tag);
      logic [4:0] obs;
      level_i = lvl;
      @(posedge clk_i);
      #1;
      step_no++;
      obs = {short_o, double_o, long_o, hold_o, busy_o};
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s step %0d: observed {s,d,l,h,b}=%05b expected %05b",
                tag, step_no, obs, exp);
      end
   endtask

   initial begin
      rst_i   = 1'b1;
      level_i = 1'b0;

      // Reset state: ARM, no pulses, busy high.
      step(1'b0, BSY, "reset");
      rst_i = 1'b0;
      step(1'b0, IDL, "arm_to_idle");
      step(1'b0, IDL, "idle");

      // Single click: 3 highs, then lows.
      for (int i = 0; i < 3; i++) step(1'b1, BSY, "single_press");
      for (int i = 0; i < 4; i++) step(1'b0, BSY, "single_gap");
      step(1'b0, SHT, "single_short");
      for (int i = 0; i < 3; i++) step(1'b0, IDL, "single_after");

      // Double click: 3 highs, 4 lows, 4 highs, low.
      for (int i = 0; i < 3; i++) step(1'b1, BSY, "dbl_press1");
      for (int i = 0; i < 4; i++) step(1'b0, BSY, "dbl_gap");
      step(1'b1, DBL, "dbl_pulse");
      for (int i = 0; i < 3; i++) step(1'b1, BSY, "dbl_press2");
      step(1'b0, IDL, "dbl_release");
      for (int i = 0; i < 6; i++) step(1'b0, IDL, "dbl_after");

      // Long press: 8 highs, hold, release.
      for (int i = 0; i < 7; i++) step(1'b1, BSY, "long_press");
      step(1'b1, LNG, "long_pulse");
      for (int i = 0; i < 2; i++) step(1'b1, HLD, "long_hold");
      step(1'b0, IDL, "long_release");
      for (int i = 0; i < 6; i++) step(1'b0, IDL, "long_after");

      // 7 highs is still a short press.
      for (int i = 0; i < 7; i++) step(1'b1, BSY, "l7_press");
      for (int i = 0; i < 4; i++) step(1'b0, BSY, "l7_gap");
      step(1'b0, SHT, "l7_short");
      step(1'b0, IDL, "l7_after");

      // Gap boundary: 5 lows closes the window; next press is independent.
      for (int i = 0; i < 3; i++) step(1'b1, BSY, "gapb_press1");
      for (int i = 0; i < 4; i++) step(1'b0, BSY, "gapb_gap1");
      step(1'b0, SHT, "gapb_short1");
      for (int i = 0; i < 3; i++) step(1'b1, BSY, "gapb_press2");
      for (int i = 0; i < 4; i++) step(1'b0, BSY, "gapb_gap2");
      step(1'b0, SHT, "gapb_short2");
      for (int i = 0; i < 2; i++) step(1'b0, IDL, "gapb_after");

      // Reset mid-press with the button held.
      for (int i = 0; i < 2; i++) step(1'b1, BSY, "rstp_press");
      rst_i = 1'b1;
      step(1'b1, BSY, "rstp_reset");
      rst_i = 1'b0;
      for (int i = 0; i < 20; i++) step(1'b1, BSY, "rstp_held");
      step(1'b0, IDL, "rstp_release");
      for (int i = 0; i < 3; i++) step(1'b1, BSY, "rstp_press2");
      for (int i = 0; i < 4; i++) step(1'b0, BSY, "rstp_gap");
      step(1'b0, SHT, "rstp_short");
      step(1'b0, IDL, "rstp_after");

      // Reset during the gap discards the pending single click.
      for (int i = 0; i < 3; i++) step(1'b1, BSY, "rstg_press");
      for (int i = 0; i < 4; i++) step(1'b0, BSY, "rstg_gap");
      rst_i = 1'b1;
      step(1'b0, BSY, "rstg_reset");
      rst_i = 1'b0;
      for (int i = 0; i < 4; i++) step(1'b0, IDL, "rstg_after");

      // Triple click: double, then a fresh sequence ending in short.
      for (int i = 0; i < 3; i++) step(1'b1, BSY, "tri_press1");
      step(1'b0, BSY, "tri_gap1");
      step(1'b1, DBL, "tri_double");
      step(1'b1, BSY, "tri_press2");
      step(1'b0, IDL, "tri_release2");
      for (int i = 0; i < 2; i++) step(1'b1, BSY, "tri_press3");
      for (int i = 0; i < 4; i++) step(1'b0, BSY, "tri_gap3");
      step(1'b0, SHT, "tri_short");
      for (int i = 0; i < 2; i++) step(1'b0, IDL, "tri_after");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
